// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART responder.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic [31:0] DEF_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] DEF_STAT_ADDR = 32'hBFD0_03FC;

    localparam int unsigned TX_IDLE_BIT  = 0;
    localparam int unsigned RX_VALID_BIT = 1;

    // Bus strobes are active-low, in line with the SELECTED/enable convention of defines.vh.
    localparam logic SELECTED = 1'b0;
    localparam logic WRITE_EN = 1'b0;
    localparam logic BYTE_EN  = 1'b0;

endpackage

// File: rtl/uart_ctrl_if.sv
// Data-side bus between the path selector and the UART responder.
interface uart_ctrl_if;
    logic        UART_CE;
    logic        UART_WE;
    logic        UART_BE;
    logic [7:0]  UART_WDATA;
    logic [31:0] UART_VADDR;
    logic [31:0] UART_RDATA;

    modport master (
        output UART_CE, UART_WE, UART_BE, UART_WDATA, UART_VADDR,
        input  UART_RDATA
    );

    modport slave (
        input  UART_CE, UART_WE, UART_BE, UART_WDATA, UART_VADDR,
        output UART_RDATA
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: RXD synchroniser, centre-sampling FSM and one-byte output register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_rxd,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_done,
    output logic       o_frame_err
);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    uart_state_t      r_state, w_state_d;
    logic             r_sync1, r_sync2, r_prev;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [2:0]       r_bit, w_bit_d;
    logic [7:0]       r_shift, w_shift_d;
    logic [7:0]       r_byte;
    logic             w_fall, w_done, w_err;

    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_bit   <= w_bit_d;
            r_shift <= w_shift_d;
            if (w_done) r_byte <= r_shift;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt + 1'b1;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_done    = 1'b0;
        w_err     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_d = '0;
                if (w_fall) w_state_d = START;
            end
            START: begin
                // Half-bit recheck rejects short low glitches.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_state_d = r_sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_d   = '0;
                    w_shift_d = {r_sync2, r_shift[7:1]};
                    w_bit_d   = r_bit + 1'b1;
                    if (r_bit == 3'd7) w_state_d = STOP;
                end
            end
            STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_d   = '0;
                    w_state_d = IDLE;
                    w_done    = r_sync2;
                    w_err     = ~r_sync2;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign o_rx_byte   = r_byte;
    assign o_rx_done   = w_done;
    assign o_frame_err = w_err;
endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART responder: TX serialiser, register decode and registered read mux.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [31:0] DATA_ADDR = DEF_DATA_ADDR,
    parameter logic [31:0] STAT_ADDR = DEF_STAT_ADDR
) (
    input  logic        CLK,
    input  logic        RST,
    uart_ctrl_if.slave  uart_bus,
    output logic        TXD,
    input  logic        RXD
);
    localparam int unsigned      CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned      CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      r_tx_state, w_tx_state_d;
    logic [CNT_W-1:0] r_tx_cnt, w_tx_cnt_d;
    logic [2:0]       r_tx_bit, w_tx_bit_d;
    logic [7:0]       r_tx_shift, w_tx_shift_d;
    logic             r_txd, w_txd_d;
    logic [31:0]      r_rdata, w_rdata_d;
    logic             r_rx_valid, w_rx_valid_d;
    logic [31:0]      w_status;
    logic             w_rd, w_wr, w_tx_idle, w_tx_accept;
    logic [7:0]       w_rx_byte;
    logic             w_rx_done, w_rx_err;

    assign w_rd = (uart_bus.UART_CE == SELECTED) && (uart_bus.UART_WE != WRITE_EN);
    assign w_wr = (uart_bus.UART_CE == SELECTED) && (uart_bus.UART_WE == WRITE_EN);
    assign w_tx_idle   = (r_tx_state == IDLE);
    assign w_tx_accept = w_wr && (uart_bus.UART_BE == BYTE_EN)
                         && (uart_bus.UART_VADDR == DATA_ADDR) && w_tx_idle;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_core (
        .CLK        (CLK),
        .RST        (RST),
        .i_rxd      (RXD),
        .o_rx_byte  (w_rx_byte),
        .o_rx_done  (w_rx_done),
        .o_frame_err(w_rx_err)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_rdata    <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_d;
            r_tx_cnt   <= w_tx_cnt_d;
            r_tx_bit   <= w_tx_bit_d;
            r_tx_shift <= w_tx_shift_d;
            r_txd      <= w_txd_d;
            r_rdata    <= w_rdata_d;
            r_rx_valid <= w_rx_valid_d;
        end
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        w_tx_cnt_d   = r_tx_cnt + 1'b1;
        w_tx_bit_d   = r_tx_bit;
        w_tx_shift_d = r_tx_shift;
        case (r_tx_state)
            IDLE: begin
                w_tx_cnt_d = '0;
                if (w_tx_accept) begin
                    w_tx_state_d = START;
                    w_tx_shift_d = uart_bus.UART_WDATA;
                    w_tx_bit_d   = '0;
                end
            end
            START: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = DATA;
                end
            end
            DATA: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_d = '0;
                    w_tx_bit_d = r_tx_bit + 1'b1;
                    if (r_tx_bit == 3'd7) w_tx_state_d = STOP;
                    else                  w_tx_shift_d = r_tx_shift >> 1;
                end
            end
            STOP: begin
                if (r_tx_cnt == BIT_LAST) begin
                    w_tx_cnt_d   = '0;
                    w_tx_state_d = IDLE;
                end
            end
            default: w_tx_state_d = IDLE;
        endcase
        // TXD is registered from next state so the line never glitches on state decode.
        case (w_tx_state_d)
            START:   w_txd_d = 1'b0;
            DATA:    w_txd_d = w_tx_shift_d[0];
            default: w_txd_d = 1'b1;
        endcase
    end

    always_comb begin
        w_status               = '0;
        w_status[TX_IDLE_BIT]  = w_tx_idle;
        w_status[RX_VALID_BIT] = r_rx_valid;
        w_rdata_d              = '0;
        w_rx_valid_d           = r_rx_valid;
        if (w_rd) begin
            if (uart_bus.UART_VADDR == DATA_ADDR) begin
                w_rdata_d    = {24'b0, w_rx_byte};
                w_rx_valid_d = 1'b0;
            end else if (uart_bus.UART_VADDR == STAT_ADDR) begin
                w_rdata_d = w_status;
            end
        end
        // A completing byte wins over a same-cycle read clear.
        if (w_rx_done && !w_rx_err) w_rx_valid_d = 1'b1;
    end

    assign uart_bus.UART_RDATA = r_rdata;
    assign TXD                 = r_txd;
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_ctrl;
    localparam int unsigned CPB   = 16;
    localparam int unsigned FRAME = 10 * CPB;
    localparam logic [31:0] DADDR = 32'hBFD0_03F8;
    localparam logic [31:0] SADDR = 32'hBFD0_03FC;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RXD = 1'b1;
    logic TXD;

    uart_ctrl_if u_if ();

    uart_ctrl #(
        .CLK_FREQ (160),
        .BAUD     (10),
        .DATA_ADDR(DADDR),
        .STAT_ADDR(SADDR)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .uart_bus(u_if),
        .TXD     (TXD),
        .RXD     (RXD)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc   = 0;
    bit          mon_en = 1'b0;

    // Reference model state: one TX frame in flight, one-byte RX buffer.
    bit          tx_active = 1'b0;
    int unsigned tx_start  = 0;
    logic [7:0]  tx_byte   = 8'h00;
    logic        rx_valid_m = 1'b0;
    logic [7:0]  rx_byte_m  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transmitter busy as seen by an access sampled at posedge number edge_k.
    function automatic bit tx_busy_at(input int unsigned edge_k);
        return tx_active && ((edge_k - tx_start) <= FRAME);
    endfunction

    function automatic logic [31:0] exp_status();
        return {30'b0, rx_valid_m, ~tx_busy_at(cyc + 1)};
    endfunction

    always @(posedge CLK) begin
        cyc++;
        if (RST) begin
            tx_active  = 1'b0;
            rx_valid_m = 1'b0;
            rx_byte_m  = 8'h00;
        end else if (u_if.UART_CE == 1'b0) begin
            if (u_if.UART_WE == 1'b0 && u_if.UART_BE == 1'b0 && u_if.UART_VADDR == DADDR
                && !tx_busy_at(cyc)) begin
                tx_active = 1'b1;
                tx_start  = cyc;
                tx_byte   = u_if.UART_WDATA;
            end
            if (u_if.UART_WE == 1'b1 && u_if.UART_VADDR == DADDR) rx_valid_m = 1'b0;
        end
    end

    // Line monitor: expected TXD derived from the frame layout {stop, data LSB first, start}.
    always @(negedge CLK) begin
        if (mon_en) begin
            int unsigned d;
            logic        e;
            d = cyc - tx_start;
            e = 1'b1;
            if (tx_active && d < FRAME) begin
                if (d < CPB)           e = 1'b0;
                else if (d < 9 * CPB)  e = tx_byte[(d - CPB) / CPB];
            end
            check($sformatf("txd_c%0d", cyc), {31'b0, TXD}, {31'b0, e});
        end
    end

    task automatic bus_idle();
        u_if.UART_CE    = 1'b1;
        u_if.UART_WE    = 1'b1;
        u_if.UART_BE    = 1'b1;
        u_if.UART_VADDR = 32'h0;
        u_if.UART_WDATA = 8'h00;
    endtask

    task automatic access(input logic ce, input logic we, input logic be,
                          input logic [31:0] addr, input logic [7:0] wd,
                          output logic [31:0] rd);
        u_if.UART_CE    = ce;
        u_if.UART_WE    = we;
        u_if.UART_BE    = be;
        u_if.UART_VADDR = addr;
        u_if.UART_WDATA = wd;
        @(negedge CLK);
        rd = u_if.UART_RDATA;
        bus_idle();
    endtask

    task automatic write_byte(input logic [7:0] b);
        logic [31:0] rd;
        access(1'b0, 1'b0, 1'b0, DADDR, b, rd);
    endtask

    task automatic rd_expect(input string name, input logic [31:0] addr,
                             input logic [31:0] exp);
        logic [31:0] rd;
        access(1'b0, 1'b1, 1'b1, addr, 8'h00, rd);
        check(name, rd, exp);
    endtask

    task automatic rd_model(input string name, input logic [31:0] addr);
        logic [31:0] exp;
        if (addr == DADDR)      exp = {24'b0, rx_byte_m};
        else if (addr == SADDR) exp = exp_status();
        else                    exp = 32'h0;
        rd_expect(name, addr, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RXD = f[i];
            repeat (CPB) @(negedge CLK);
        end
        RXD = 1'b1;
        if (stop) begin
            rx_byte_m  = b;
            rx_valid_m = 1'b1;
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    typedef struct {
        logic        ce;
        logic        we;
        logic        be;
        logic [31:0] addr;
        logic [7:0]  wd;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0]  rd;
        int unsigned  t0;
        logic [7:0]   btx, brx;
        logic [31:0]  raddr;

        bus_idle();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        mon_en = 1'b1;
        check("rdata_reset", u_if.UART_RDATA, 32'h0);

        // Register map after reset, and writes that must have no effect.
        vecs[0] = '{1'b0, 1'b1, 1'b1, SADDR,         8'h00, 1'b1, 32'h1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, SADDR,         8'h00, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, DADDR,         8'h00, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'hBFD0_03F0, 8'h00, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, DADDR,         8'h5A, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 1'b0, SADDR,         8'h5A, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, DADDR,         8'h5A, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, SADDR,         8'h00, 1'b1, 32'h1};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 8'h00, 1'b1, 32'h0};
        for (int i = 0; i < 9; i++) begin
            access(vecs[i].ce, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, rd);
            if (vecs[i].chk) check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end
        repeat (20) @(negedge CLK);
        rd_expect("stat_after_nop_writes", SADDR, 32'h1);

        // TX 0xA5: status busy through the last stop cycle, idle right after.
        write_byte(8'hA5);
        t0 = cyc;
        while (cyc + 1 < t0 + 40) @(negedge CLK);
        rd_expect("stat_tx_mid", SADDR, 32'h0);
        while (cyc + 1 < t0 + FRAME) @(negedge CLK);
        rd_expect("stat_tx_last_stop", SADDR, 32'h0);
        rd_expect("stat_tx_done", SADDR, 32'h1);

        // Back-to-back writes: second one is dropped.
        write_byte(8'h11);
        write_byte(8'h22);
        repeat (FRAME + 10) @(negedge CLK);

        // RX 0x3C.
        send_frame(8'h3C, 1'b1);
        rd_expect("rx_stat_valid", SADDR, 32'h3);
        rd_expect("rx_data_3c", DADDR, 32'h3C);
        rd_expect("rx_stat_cleared", SADDR, 32'h1);

        // Short low glitch, then a clean frame.
        RXD = 1'b0;
        repeat (5) @(negedge CLK);
        RXD = 1'b1;
        repeat (12) @(negedge CLK);
        rd_expect("glitch_no_byte", SADDR, 32'h1);
        send_frame(8'h55, 1'b1);
        rd_expect("rx_data_55", DADDR, 32'h55);

        // Framing error discarded; then overrun keeps the latest byte.
        send_frame(8'h81, 1'b0);
        repeat (8) @(negedge CLK);
        rd_expect("frame_err_stat", SADDR, 32'h1);
        send_frame(8'h12, 1'b1);
        send_frame(8'h7E, 1'b1);
        rd_expect("overrun_stat", SADDR, 32'h3);
        rd_expect("overrun_data", DADDR, 32'h7E);
        rd_expect("overrun_cleared", SADDR, 32'h1);

        // Reset in the middle of a TX frame.
        write_byte(8'hC3);
        t0 = cyc;
        while (cyc + 1 < t0 + 49) @(negedge CLK);
        rd_expect("pre_rst_data", DADDR, 32'h7E);
        pulse_reset();
        check("rdata_after_rst", u_if.UART_RDATA, 32'h0);
        rd_expect("stat_after_rst", SADDR, 32'h1);
        rd_expect("rxbyte_after_rst", DADDR, 32'h0);
        write_byte(8'h96);
        repeat (FRAME + 10) @(negedge CLK);

        // Reset in the middle of an RX frame.
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
        pulse_reset();
        repeat (2 * FRAME) @(negedge CLK);
        rd_expect("rx_rst_stat", SADDR, 32'h1);
        send_frame(8'hA3, 1'b1);
        rd_expect("rx_after_rst", DADDR, 32'hA3);

        // Randomised traffic: concurrent TX/RX, optional dropped write, model-checked reads.
        for (int i = 0; i < 8; i++) begin
            btx = 8'($urandom);
            brx = 8'($urandom);
            write_byte(btx);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 3)) @(negedge CLK);
                write_byte(8'($urandom));
            end
            send_frame(brx, 1'b1);
            repeat ($urandom_range(0, 8)) @(negedge CLK);
            rd_model($sformatf("rnd%0d_stat", i), SADDR);
            rd_model($sformatf("rnd%0d_data", i), DADDR);
            rd_model($sformatf("rnd%0d_stat2", i), SADDR);
            raddr = $urandom;
            rd_model($sformatf("rnd%0d_addr", i), raddr);
        end
        repeat (FRAME + 10) @(negedge CLK);
        rd_model("final_stat", SADDR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
